// File: rtl/prog_sequencer.sv
// Run controller for the 9-bit ISA processor.
// Runs programs 0..NPROG-1 back to back. Each program gets a Start strobe,
// then the controller waits for the processor's halt flag (Ack). It records
// how long each run took and gives up on a program that runs too long.
module prog_sequencer #(
    parameter int NPROG     = 3,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 4096,
    parameter int CW        = 16,
    localparam int SW       = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic          Abort,
    input  logic          Ack,
    output logic          Start,
    output logic [SW-1:0] ProgSel,
    output logic          Busy,
    output logic          ProgDone,
    output logic [CW-1:0] RunCycles,
    output logic          Done,
    output logic          TimedOut
);

    // Counter widths are sized so each counter can hold its terminal value.
    localparam int STW = $clog2(START_CYC) + 1;
    localparam int TW  = $clog2(TIMEOUT) + 1;

    localparam logic [STW-1:0] START_LAST = STW'(START_CYC - 1);
    localparam logic [TW-1:0]  TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0]  SEL_LAST   = SW'(NPROG - 1);
    localparam logic [CW-1:0]  RUN_MAX    = {CW{1'b1}};

    typedef enum logic [2:0] {
        sIdle,
        sStart,
        sArm,
        sRun,
        sReport,
        sDone,
        sFault
    } stateT;

    stateT          stateReg;
    logic [STW-1:0] startCntReg;
    logic [TW-1:0]  toCntReg;
    logic [CW-1:0]  runCntReg;

    // State machine with registered outputs. Abort overrides everything
    // except reset. Exits from ARM/RUN are checked before the timeout, so an
    // Ack on the last allowed cycle still completes the program.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stateReg    <= sIdle;
            startCntReg <= '0;
            toCntReg    <= '0;
            runCntReg   <= '0;
            Start       <= 1'b0;
            ProgSel     <= '0;
            Busy        <= 1'b0;
            ProgDone    <= 1'b0;
            RunCycles   <= '0;
            Done        <= 1'b0;
            TimedOut    <= 1'b0;
        end else if (Abort) begin
            stateReg    <= sIdle;
            startCntReg <= '0;
            toCntReg    <= '0;
            runCntReg   <= '0;
            Start       <= 1'b0;
            ProgSel     <= '0;
            Busy        <= 1'b0;
            ProgDone    <= 1'b0;
            RunCycles   <= '0;
            Done        <= 1'b0;
            TimedOut    <= 1'b0;
        end else begin
            case (stateReg)
                sIdle, sDone, sFault: begin
                    // Go is only honoured while no sequence is in flight.
                    if (Go) begin
                        stateReg    <= sStart;
                        ProgSel     <= '0;
                        startCntReg <= '0;
                        toCntReg    <= '0;
                        Start       <= 1'b1;
                        Busy        <= 1'b1;
                        Done        <= 1'b0;
                        TimedOut    <= 1'b0;
                    end
                end
                sStart: begin
                    // Ack is ignored here; it may still be high from the last halt.
                    if (startCntReg == START_LAST) begin
                        stateReg <= sArm;
                        Start    <= 1'b0;
                        toCntReg <= '0;
                    end else begin
                        startCntReg <= startCntReg + STW'(1);
                    end
                end
                sArm: begin
                    // Wait for the previous program's halt flag to clear.
                    if (!Ack) begin
                        stateReg  <= sRun;
                        runCntReg <= '0;
                        toCntReg  <= toCntReg + TW'(1);
                    end else if (toCntReg == TO_LAST) begin
                        stateReg <= sFault;
                        Busy     <= 1'b0;
                        TimedOut <= 1'b1;
                    end else begin
                        toCntReg <= toCntReg + TW'(1);
                    end
                end
                sRun: begin
                    if (Ack) begin
                        stateReg  <= sReport;
                        RunCycles <= runCntReg;
                        ProgDone  <= 1'b1;
                    end else if (toCntReg == TO_LAST) begin
                        stateReg <= sFault;
                        Busy     <= 1'b0;
                        TimedOut <= 1'b1;
                    end else begin
                        toCntReg <= toCntReg + TW'(1);
                        if (runCntReg != RUN_MAX) begin
                            runCntReg <= runCntReg + CW'(1);
                        end
                    end
                end
                sReport: begin
                    ProgDone <= 1'b0;
                    if (ProgSel == SEL_LAST) begin
                        stateReg <= sDone;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                    end else begin
                        stateReg    <= sStart;
                        ProgSel     <= ProgSel + SW'(1);
                        startCntReg <= '0;
                        toCntReg    <= '0;
                        Start       <= 1'b1;
                    end
                end
                default: begin
                    stateReg <= sIdle;
                    Start    <= 1'b0;
                    Busy     <= 1'b0;
                    ProgDone <= 1'b0;
                    Done     <= 1'b0;
                    TimedOut <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer. Stimulus pushes the expected
// (ProgSel, RunCycles) of each program onto a scoreboard; a monitor pops
// and compares on every ProgDone pulse.
// The DUT uses TIMEOUT=24 and CW=4 so that saturation and the timeout
// boundary are both reachable within short runs.
module tb_prog_sequencer;

    localparam int NPROG     = 3;
    localparam int START_CYC = 2;
    localparam int TIMEOUT   = 24;
    localparam int CW        = 4;
    localparam int RUN_SAT   = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Go;
    logic          Abort;
    logic          Ack;
    logic          Start;
    logic [1:0]    ProgSel;
    logic          Busy;
    logic          ProgDone;
    logic [CW-1:0] RunCycles;
    logic          Done;
    logic          TimedOut;

    int total = 0;
    int bad   = 0;
    int expSelQ[$];
    int expCycQ[$];

    prog_sequencer #(
        .NPROG    (NPROG),
        .START_CYC(START_CYC),
        .TIMEOUT  (TIMEOUT),
        .CW       (CW)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Go       (Go),
        .Abort    (Abort),
        .Ack      (Ack),
        .Start    (Start),
        .ProgSel  (ProgSel),
        .Busy     (Busy),
        .ProgDone (ProgDone),
        .RunCycles(RunCycles),
        .Done     (Done),
        .TimedOut (TimedOut)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ProgDone cycle must match the next expectation.
    always @(negedge Clk) begin
        if (ProgDone === 1'b1) begin
            total++;
            if (expSelQ.size() == 0) begin
                bad++;
                $display("FAIL progdone_unexpected: got sel=%0d cycles=%0d expected no pulse", ProgSel, RunCycles);
            end else begin
                int s;
                int c;
                s = expSelQ.pop_front();
                c = expCycQ.pop_front();
                if (ProgSel !== 2'(s) || RunCycles !== CW'(c)) begin
                    bad++;
                    $display("FAIL progdone_result: got sel=%0d cycles=%0d expected sel=%0d cycles=%0d",
                             ProgSel, RunCycles, s, c);
                end else begin
                    $display("progdone sel=%0d cycles=%0d", ProgSel, RunCycles);
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_start"}, Start, 0);
        check({tag, "_progsel"}, ProgSel, 0);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_progdone"}, ProgDone, 0);
        check({tag, "_runcycles"}, RunCycles, 0);
        check({tag, "_done"}, Done, 0);
        check({tag, "_timedout"}, TimedOut, 0);
    endtask

    task automatic pulseGo();
        Go = 1'b1;
        step();
        Go = 1'b0;
    endtask

    // Wait for Start, then check its index and width; returns in ARM.
    task automatic armWait(input int sel);
        int n;
        for (int i = 0; i < 20 && Start !== 1'b1; i++) step();
        check("start_seen", Start, 1);
        check("progsel_at_start", ProgSel, sel);
        check("busy_at_start", Busy, 1);
        n = 0;
        while (Start === 1'b1 && n < 10) begin
            n++;
            step();
        end
        check("start_width", n, START_CYC);
    endtask

    // One program: Ack stays high for armHold ARM cycles, then one low cycle
    // releases ARM and runLen low cycles are counted in RUN before Ack rises.
    task automatic runProg(input int sel, input int armHold, input int runLen, input bit goInArm);
        armWait(sel);
        for (int i = 0; i < armHold; i++) begin
            if (goInArm) Go = 1'b1;
            step();
            Go = 1'b0;
        end
        Ack = 1'b0;
        repeat (runLen + 1) step();
        expSelQ.push_back(sel);
        expCycQ.push_back(runLen > RUN_SAT ? RUN_SAT : runLen);
        Ack = 1'b1;
        step();
    endtask

    task automatic checkDone();
        step();
        check("done_flag", Done, 1);
        check("done_busy", Busy, 0);
        check("done_progsel", ProgSel, NPROG - 1);
        check("done_timedout", TimedOut, 0);
    endtask

    initial begin
        int k;
        Reset = 1'b0;
        Go    = 1'b0;
        Abort = 1'b0;
        Ack   = 1'b1;
        #12;
        checkIdleOutputs("reset");
        Reset = 1'b1;
        step();

        // Full sequence; Go pulsed during a busy ARM must be ignored.
        $display("seq1: three programs of 10 run cycles");
        pulseGo();
        runProg(0, 3, 10, 1'b0);
        runProg(1, 3, 10, 1'b1);
        runProg(2, 3, 10, 1'b0);
        checkDone();

        // Restart from DONE; saturating run that completes on the timeout cycle.
        $display("seq2: saturation, Ack on last allowed cycle, zero-length run");
        pulseGo();
        check("restart_done_cleared", Done, 0);
        check("restart_start", Start, 1);
        check("restart_progsel", ProgSel, 0);
        runProg(0, 2, 20, 1'b0);
        runProg(1, 0, 7, 1'b0);
        runProg(2, 1, 0, 1'b0);
        checkDone();

        // Program 1 never halts.
        $display("seq3: timeout on program 1");
        pulseGo();
        runProg(0, 1, 5, 1'b0);
        armWait(1);
        Ack = 1'b0;
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (TimedOut === 1'b1) begin
                k = i;
                break;
            end
        end
        check("timeout_latency", k, TIMEOUT);
        check("fault_start", Start, 0);
        check("fault_progsel", ProgSel, 1);
        check("fault_runcycles", RunCycles, 5);
        check("fault_busy", Busy, 0);
        pulseGo();
        check("fault_restart_timedout", TimedOut, 0);
        check("fault_restart_progsel", ProgSel, 0);
        check("fault_restart_start", Start, 1);

        // Abort with Go during program 1's RUN.
        $display("seq4: abort mid-run");
        runProg(0, 0, 4, 1'b0);
        armWait(1);
        Ack = 1'b0;
        repeat (3) step();
        Abort = 1'b1;
        Go    = 1'b1;
        step();
        checkIdleOutputs("abort");
        Abort = 1'b0;
        Go    = 1'b0;
        repeat (3) step();
        check("abort_stays_idle_start", Start, 0);
        check("abort_stays_idle_busy", Busy, 0);

        // Asynchronous reset between clock edges while Start is high.
        $display("seq5: async reset mid-start then clean sequence");
        Ack = 1'b1;
        pulseGo();
        check("pre_reset_start", Start, 1);
        #2;
        Reset = 1'b0;
        #1;
        checkIdleOutputs("async_reset");
        #10;
        Reset = 1'b1;
        step();
        pulseGo();
        runProg(0, 3, 10, 1'b0);
        runProg(1, 3, 10, 1'b0);
        runProg(2, 3, 10, 1'b0);
        checkDone();

        step();
        check("scoreboard_drained", expSelQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
